// File: rtl/jtopl_csr_q_if.sv
// jtopl_csr_q_if: register-side bus of jtopl_csr_q (queued writes, ring view, readback).
// master = register interface / CPU side, slave = the CSR ring.
interface jtopl_csr_q_if #(
   parameter int unsigned LEN  = 18,
   parameter int unsigned NREG = 5
);
   localparam int unsigned W  = 8 * NREG;
   localparam int unsigned SW = $clog2(LEN);
   localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;

   logic          cen;
   logic          wr;
   logic [SW-1:0] wr_slot;
   logic [RW-1:0] wr_reg;
   logic [7:0]    wr_din;
   logic [7:0]    wr_mask;
   logic          wr_rdy;
   logic          wr_err;
   logic [SW-1:0] cur_slot;
   logic [W-1:0]  shift_out;
   logic          rd;
   logic [SW-1:0] rd_slot;
   logic [RW-1:0] rd_reg;
   logic          rd_busy;
   logic          rd_valid;
   logic [7:0]    rd_dout;

   modport master (
      output cen, wr, wr_slot, wr_reg, wr_din, wr_mask, rd, rd_slot, rd_reg,
      input  wr_rdy, wr_err, cur_slot, shift_out, rd_busy, rd_valid, rd_dout
   );

   modport slave (
      input  cen, wr, wr_slot, wr_reg, wr_din, wr_mask, rd, rd_slot, rd_reg,
      output wr_rdy, wr_err, cur_slot, shift_out, rd_busy, rd_valid, rd_dout
   );
endinterface

// File: rtl/jtopl_csr_q.sv
// jtopl_csr_q: circular shift register of per-slot register bytes with a queued masked-write
// merge at the ring input. Readback FSM enabled by defining JTOPL_CSR_READBACK_EN.
module jtopl_csr_q #(
   parameter int unsigned LEN    = 18,
   parameter int unsigned NREG   = 5,
   parameter int unsigned QDEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   jtopl_csr_q_if.slave bus
);
   localparam int unsigned W  = 8 * NREG;
   localparam int unsigned SW = $clog2(LEN);
   localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int unsigned AW = $clog2(QDEPTH);

   typedef struct packed {
      logic [SW-1:0] slot;
      logic [RW-1:0] breg;
      logic [7:0]    din;
      logic [7:0]    mask;
   } wr_entry_t;

   logic [W-1:0]  ring_q [LEN];
   logic [SW-1:0] cur_slot_q, cur_slot_d;
   wr_entry_t     fifo_q [QDEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q, count_d;
   logic          wr_rdy_q, wr_err_q;
   wr_entry_t     head;
   logic          wr_ok, push, pop;
   logic [W-1:0]  merged;

   assign head  = fifo_q[rptr_q];
   assign wr_ok = (32'(bus.wr_slot) < LEN) && (32'(bus.wr_reg) < NREG);

   // Only the FIFO head is examined, so writes land strictly in acceptance order.
   always_comb begin
      push       = bus.wr && wr_rdy_q && wr_ok;
      pop        = bus.cen && (count_q != '0) && (head.slot == cur_slot_q);
      count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
      cur_slot_d = (32'(cur_slot_q) == LEN - 1) ? '0 : cur_slot_q + 1'b1;
      merged     = ring_q[LEN-1];
      if (pop) begin
         for (int unsigned k = 0; k < NREG; k++) begin
            if (32'(head.breg) == k)
               merged[8*k +: 8] = (head.din & head.mask) | (ring_q[LEN-1][8*k +: 8] & ~head.mask);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < LEN; i++) ring_q[i] <= '0;
         cur_slot_q <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         wr_rdy_q   <= 1'b1;
         wr_err_q   <= 1'b0;
      end else begin
         if (bus.cen) begin
            ring_q[0] <= merged;
            for (int unsigned i = 1; i < LEN; i++) ring_q[i] <= ring_q[i-1];
            cur_slot_q <= cur_slot_d;
         end
         if (push) begin
            fifo_q[wptr_q] <= '{bus.wr_slot, bus.wr_reg, bus.wr_din, bus.wr_mask};
            wptr_q         <= wptr_q + 1'b1;
         end
         if (pop) rptr_q <= rptr_q + 1'b1;
         count_q  <= count_d;
         // Readiness follows the post-update count; acceptance always uses the registered value.
         wr_rdy_q <= (count_d != (AW+1)'(QDEPTH));
         wr_err_q <= bus.wr && wr_rdy_q && !wr_ok;
      end
   end

   assign bus.wr_rdy    = wr_rdy_q;
   assign bus.wr_err    = wr_err_q;
   assign bus.cur_slot  = cur_slot_q;
   assign bus.shift_out = ring_q[LEN-1];

`ifdef JTOPL_CSR_READBACK_EN
   typedef enum logic {RD_IDLE, RD_WAIT} rd_state_t;

   rd_state_t     rd_state_q, rd_state_d;
   logic [SW-1:0] rd_slot_q, rd_slot_d;
   logic [RW-1:0] rd_reg_q, rd_reg_d;
   logic          rd_valid_q, rd_valid_d;
   logic [7:0]    rd_dout_q, rd_dout_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_q <= RD_IDLE;
         rd_slot_q  <= '0;
         rd_reg_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_dout_q  <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_slot_q  <= rd_slot_d;
         rd_reg_q   <= rd_reg_d;
         rd_valid_q <= rd_valid_d;
         rd_dout_q  <= rd_dout_d;
      end
   end

   // Sampling the pre-merge ring output makes a same-slot write in flight return the old byte.
   always_comb begin
      rd_state_d = rd_state_q;
      rd_slot_d  = rd_slot_q;
      rd_reg_d   = rd_reg_q;
      rd_valid_d = 1'b0;
      rd_dout_d  = rd_dout_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (bus.rd) begin
               rd_slot_d  = bus.rd_slot;
               rd_reg_d   = bus.rd_reg;
               rd_state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (bus.cen && (cur_slot_q == rd_slot_q)) begin
               rd_dout_d = '0;
               for (int unsigned k = 0; k < NREG; k++) begin
                  if (32'(rd_reg_q) == k) rd_dout_d = ring_q[LEN-1][8*k +: 8];
               end
               rd_valid_d = 1'b1;
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   assign bus.rd_busy  = (rd_state_q == RD_WAIT);
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_dout  = rd_dout_q;
`else
   assign bus.rd_busy  = 1'b0;
   assign bus.rd_valid = 1'b0;
   assign bus.rd_dout  = '0;
`endif
endmodule

// File: tb/tb_jtopl_csr_q.sv
// tb_jtopl_csr_q: randomized and directed stimulus for jtopl_csr_q, checked every cycle
// against a slot-array/queue reference model (readback expectations follow JTOPL_CSR_READBACK_EN).
module tb_jtopl_csr_q;
   localparam int unsigned LEN    = 18;
   localparam int unsigned NREG   = 5;
   localparam int unsigned QDEPTH = 4;
   localparam int unsigned W      = 8 * NREG;
   localparam int unsigned SW     = $clog2(LEN);
   localparam int unsigned RW     = (NREG > 1) ? $clog2(NREG) : 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jtopl_csr_q_if #(.LEN(LEN), .NREG(NREG)) bus ();

   jtopl_csr_q #(.LEN(LEN), .NREG(NREG), .QDEPTH(QDEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: contents by slot number, a queue of pending writes, and the slot at the output.
   typedef struct { int slot; int breg; logic [7:0] din; logic [7:0] mask; } wr_t;
   wr_t        q[$];
   logic [7:0] mem [LEN][NREG];
   int         m_cur;
   bit         m_rdy, m_err, m_busy, m_valid;
   logic [7:0] m_dout;
   int         m_rslot, m_rreg;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit acc, ok;
      if (rst) begin
         foreach (mem[s, k]) mem[s][k] = 8'h00;
         q.delete();
         m_cur = 0; m_rdy = 1; m_err = 0;
         m_busy = 0; m_valid = 0; m_dout = 8'h00; m_rslot = 0; m_rreg = 0;
         return;
      end
      m_valid = 0;
`ifdef JTOPL_CSR_READBACK_EN
      if (m_busy) begin
         if (bus.cen && m_cur == m_rslot) begin
            m_valid = 1;
            m_dout  = mem[m_cur][m_rreg];
            m_busy  = 0;
         end
      end else if (bus.rd) begin
         m_busy  = 1;
         m_rslot = int'(bus.rd_slot);
         m_rreg  = int'(bus.rd_reg);
      end
`endif
      acc   = bus.wr && m_rdy;
      ok    = (int'(bus.wr_slot) < LEN) && (int'(bus.wr_reg) < NREG);
      m_err = acc && !ok;
      if (bus.cen) begin
         if (q.size() > 0 && q[0].slot == m_cur) begin
            mem[m_cur][q[0].breg] = (q[0].din & q[0].mask) | (mem[m_cur][q[0].breg] & ~q[0].mask);
            void'(q.pop_front());
         end
         m_cur = (m_cur + 1) % LEN;
      end
      if (acc && ok)
         q.push_back('{int'(bus.wr_slot), int'(bus.wr_reg), bus.wr_din, bus.wr_mask});
      m_rdy = (q.size() < QDEPTH);
   endtask

   task automatic compare_all();
      logic [W-1:0] exp_so;
      exp_so = '0;
      for (int k = 0; k < NREG; k++) exp_so[8*k +: 8] = mem[m_cur][k];
      check("cur_slot",  64'(bus.cur_slot),  64'(m_cur));
      check("shift_out", 64'(bus.shift_out), 64'(exp_so));
      check("wr_rdy",    64'(bus.wr_rdy),    64'(m_rdy));
      check("wr_err",    64'(bus.wr_err),    64'(m_err));
      check("rd_busy",   64'(bus.rd_busy),   64'(m_busy));
      check("rd_valid",  64'(bus.rd_valid),  64'(m_valid));
      check("rd_dout",   64'(bus.rd_dout),   64'(m_dout));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      bus.wr = 0; bus.rd = 0;
   endtask

   task automatic do_write(input int s, input int r, input logic [7:0] d, input logic [7:0] m);
      bus.wr = 1; bus.wr_slot = SW'(s); bus.wr_reg = RW'(r); bus.wr_din = d; bus.wr_mask = m;
      tick();
      bus.wr = 0;
   endtask

   task automatic wait_cur(input int s);
      for (int i = 0; i <= LEN && m_cur != s; i++) tick();
      check("wait_cur_timeout", 64'(m_cur == s), 64'd1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      bus.cen = 0; bus.wr = 0; bus.wr_slot = '0; bus.wr_reg = '0; bus.wr_din = '0; bus.wr_mask = '0;
      bus.rd = 0; bus.rd_slot = '0; bus.rd_reg = '0;

      // Reset and free-running ring
      rst = 1; run(2);
      check("reset_cur_slot", 64'(bus.cur_slot), 64'd0);
      check("reset_wr_rdy",   64'(bus.wr_rdy),   64'd1);
      rst = 0; bus.cen = 1;
      run(40);

      // Full-mask write to slot 5 byte 2 issued at cur_slot 3
      wait_cur(3);
      do_write(5, 2, 8'hA5, 8'hFF);
      run(2 * LEN);
      wait_cur(5);
      check("slot5_byte2", 64'(bus.shift_out[23:16]), 64'hA5);

      // Partial mask merge on slot 7 byte 0
      do_write(7, 0, 8'h0F, 8'hFF);
      do_write(7, 0, 8'hF0, 8'hC0);
      run(3 * LEN);
      wait_cur(7);
      check("slot7_byte0", 64'(bus.shift_out[7:0]), 64'hCF);

      // Fill the FIFO with the ring stopped, then drain
      bus.cen = 0;
      for (int i = 0; i < 4; i++) do_write(i + 1, 0, 8'(8'h10 + i), 8'hFF);
      check("full_wr_rdy", 64'(bus.wr_rdy), 64'd0);
      do_write(9, 1, 8'h77, 8'hFF);
      run(3);
      bus.cen = 1;
      for (int i = 0; i < 5 * LEN && q.size() > 0; i++) tick();
      check("drain_timeout", 64'(q.size()), 64'd0);
      run(LEN + 2);

      // Bad slot / bad register
      do_write(LEN, 0, 8'h11, 8'hFF);
      check("err_slot", 64'(bus.wr_err), 64'd1);
      tick();
      check("err_clear", 64'(bus.wr_err), 64'd0);
      do_write(3, NREG, 8'h22, 8'hFF);
      check("err_reg", 64'(bus.wr_err), 64'd1);
      tick();

`ifdef JTOPL_CSR_READBACK_EN
      // Readback of slot 5 byte 2
      bus.rd = 1; bus.rd_slot = SW'(5); bus.rd_reg = RW'(2);
      tick();
      bus.rd = 0;
      for (int i = 0; i < 2 * LEN && !bus.rd_valid; i++) tick();
      check("rd_valid_seen", 64'(bus.rd_valid), 64'd1);
      check("rd_dout_a5",    64'(bus.rd_dout),  64'hA5);
      // Reset while waiting
      bus.rd = 1; bus.rd_slot = SW'((m_cur + LEN - 1) % LEN); bus.rd_reg = RW'(0);
      tick();
      bus.rd = 0;
      run(2);
      check("rd_busy_wait", 64'(bus.rd_busy), 64'd1);
      rst = 1; tick(); rst = 0;
      check("rd_busy_rst",  64'(bus.rd_busy),  64'd0);
      check("rd_valid_rst", 64'(bus.rd_valid), 64'd0);
      run(LEN + 2);
`endif

      // Randomized traffic
      for (int i = 0; i < 900; i++) begin
         rst         = ($urandom_range(0, 199) == 0);
         bus.cen     = ($urandom_range(0, 3) != 0);
         bus.wr      = ($urandom_range(0, 2) == 0);
         bus.wr_slot = SW'($urandom_range(0, LEN));
         bus.wr_reg  = RW'($urandom_range(0, NREG));
         bus.wr_din  = 8'($urandom);
         bus.wr_mask = 8'($urandom);
         bus.rd      = ($urandom_range(0, 7) == 0);
         bus.rd_slot = SW'($urandom_range(0, LEN - 1));
         bus.rd_reg  = RW'($urandom_range(0, NREG - 1));
         tick();
      end
      rst = 0;
      idle_inputs();
      bus.cen = 1;
      run(2 * LEN);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
